// File: rtl/dense_layer.sv
// Fully-connected layer: one MAC per cycle over IN_DIM inputs for each of OUT_DIM neurons,
// streaming saturated logits and reporting the argmax class when the last neuron is written.
module dense_layer #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 7,
  parameter int IN_DIM     = 1568,
  parameter int OUT_DIM    = 10
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  output logic [$clog2(IN_DIM)-1:0]             in_addr,
  output logic                                  in_en,
  input  logic signed [DATA_WIDTH-1:0]          in_q,
  output logic [$clog2(IN_DIM*OUT_DIM)-1:0]     w_addr,
  output logic                                  w_en,
  input  logic signed [DATA_WIDTH-1:0]          w_q,
  output logic [$clog2(OUT_DIM)-1:0]            b_addr,
  output logic                                  b_en,
  input  logic signed [DATA_WIDTH-1:0]          b_q,
  output logic                                  out_valid,
  output logic [$clog2(OUT_DIM)-1:0]            out_idx,
  output logic signed [DATA_WIDTH-1:0]          out_data,
  output logic [$clog2(OUT_DIM)-1:0]            class_idx,
  output logic                                  busy,
  output logic                                  done
);

  localparam int ACC_WIDTH = 2*DATA_WIDTH + $clog2(IN_DIM) + 1;
  localparam int K_W  = $clog2(IN_DIM);
  localparam int N_W  = $clog2(OUT_DIM);
  localparam int WA_W = $clog2(IN_DIM*OUT_DIM);
  localparam logic [K_W-1:0] K_LAST = K_W'(IN_DIM-1);
  localparam logic [N_W-1:0] N_LAST = N_W'(OUT_DIM-1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_DRAIN, S_WRITE, S_FINISH} state_t;

  state_t                        state_reg, state_next;
  logic [K_W-1:0]                k_reg;
  logic [N_W-1:0]                n_reg;
  logic [WA_W-1:0]               w_base_reg;
  logic signed [ACC_WIDTH-1:0]   acc_reg;
  logic signed [DATA_WIDTH-1:0]  max_reg;
  logic [N_W-1:0]                best_reg;
  logic [N_W-1:0]                class_reg;

  logic signed [2*DATA_WIDTH-1:0] product;
  logic signed [ACC_WIDTH-1:0]    product_ext;
  logic signed [ACC_WIDTH-1:0]    bias_ext;
  logic signed [ACC_WIDTH-1:0]    shifted;
  logic signed [DATA_WIDTH-1:0]   sat_val;
  logic                           take_new;

  // Product of the element whose ROM reads were issued in the previous cycle.
  assign product     = in_q * w_q;
  assign product_ext = ACC_WIDTH'(product);
  assign bias_ext    = ACC_WIDTH'(b_q) <<< FRAC_BITS;
  assign shifted     = acc_reg >>> FRAC_BITS;
  assign sat_val     = (shifted > SAT_MAX) ? SAT_MAX[DATA_WIDTH-1:0] :
                       (shifted < SAT_MIN) ? SAT_MIN[DATA_WIDTH-1:0] :
                       shifted[DATA_WIDTH-1:0];
  // Strict compare so ties keep the lower neuron index.
  assign take_new    = (n_reg == '0) || (sat_val > max_reg);
  assign class_idx   = class_reg;

  always_comb begin
    state_next = state_reg;
    in_en      = 1'b0;
    w_en       = 1'b0;
    b_en       = 1'b0;
    in_addr    = '0;
    w_addr     = '0;
    b_addr     = '0;
    out_valid  = 1'b0;
    out_idx    = '0;
    out_data   = '0;
    done       = 1'b0;
    busy       = (state_reg != S_IDLE);
    case (state_reg)
      S_IDLE:   if (start) state_next = S_LOAD;
      S_LOAD: begin
        b_en       = 1'b1;
        b_addr     = n_reg;
        state_next = S_MAC;
      end
      S_MAC: begin
        in_en   = 1'b1;
        w_en    = 1'b1;
        in_addr = k_reg;
        w_addr  = w_base_reg + WA_W'(k_reg);
        if (k_reg == K_LAST) state_next = S_DRAIN;
      end
      S_DRAIN:  state_next = S_WRITE;
      S_WRITE: begin
        out_valid  = 1'b1;
        out_idx    = n_reg;
        out_data   = sat_val;
        state_next = (n_reg == N_LAST) ? S_FINISH : S_LOAD;
      end
      S_FINISH: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      k_reg      <= '0;
      n_reg      <= '0;
      w_base_reg <= '0;
      acc_reg    <= '0;
      max_reg    <= '0;
      best_reg   <= '0;
      class_reg  <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: if (start) begin
          n_reg      <= '0;
          k_reg      <= '0;
          w_base_reg <= '0;
          acc_reg    <= '0;
        end
        S_LOAD: k_reg <= '0;
        S_MAC: begin
          acc_reg <= (k_reg == '0) ? bias_ext : acc_reg + product_ext;
          if (k_reg != K_LAST) k_reg <= k_reg + 1'b1;
        end
        S_DRAIN: acc_reg <= acc_reg + product_ext;
        S_WRITE: begin
          if (take_new) begin
            max_reg  <= sat_val;
            best_reg <= n_reg;
          end
          if (n_reg == N_LAST) begin
            class_reg <= take_new ? n_reg : best_reg;
          end else begin
            n_reg      <= n_reg + 1'b1;
            w_base_reg <= w_base_reg + WA_W'(IN_DIM);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_layer.sv
// Directed bench for dense_layer (IN_DIM=4, OUT_DIM=3): ROM models, reference model and
// a scoreboard of expected logits compared as out_valid pulses arrive.
module tb_dense_layer;
  localparam int DW  = 16;
  localparam int IN  = 4;
  localparam int OUT = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [1:0] in_addr;
  logic in_en;
  logic signed [DW-1:0] in_q = '0;
  logic [3:0] w_addr;
  logic w_en;
  logic signed [DW-1:0] w_q = '0;
  logic [1:0] b_addr;
  logic b_en;
  logic signed [DW-1:0] b_q = '0;
  logic out_valid;
  logic [1:0] out_idx;
  logic signed [DW-1:0] out_data;
  logic [1:0] class_idx;
  logic busy;
  logic done;

  always #5 clk = ~clk;

  dense_layer #(.DATA_WIDTH(DW), .FRAC_BITS(7), .IN_DIM(IN), .OUT_DIM(OUT)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_addr(in_addr), .in_en(in_en), .in_q(in_q),
    .w_addr(w_addr), .w_en(w_en), .w_q(w_q),
    .b_addr(b_addr), .b_en(b_en), .b_q(b_q),
    .out_valid(out_valid), .out_idx(out_idx), .out_data(out_data),
    .class_idx(class_idx), .busy(busy), .done(done)
  );

  logic signed [DW-1:0] in_mem [IN];
  logic signed [DW-1:0] w_mem  [IN*OUT];
  logic signed [DW-1:0] b_mem  [OUT];

  always @(posedge clk) begin
    if (in_en) in_q <= in_mem[in_addr];
    if (w_en)  w_q  <= w_mem[w_addr];
    if (b_en)  b_q  <= b_mem[b_addr];
  end

  typedef struct { int idx; int data; } exp_t;
  exp_t sb[$];
  int exp_class;
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: floor-shifted, saturated dot product plus bias; argmax with strict compare.
  task automatic build_expect();
    longint acc;
    longint v;
    int best_v;
    exp_t e;
    sb.delete();
    best_v = 0;
    exp_class = 0;
    for (int n = 0; n < OUT; n++) begin
      acc = longint'(b_mem[n]) * 128;
      for (int k = 0; k < IN; k++)
        acc += longint'(in_mem[k]) * longint'(w_mem[n*IN+k]);
      v = acc >>> 7;
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
      e.idx = n;
      e.data = int'(v);
      sb.push_back(e);
      if (n == 0 || int'(v) > best_v) begin
        best_v = int'(v);
        exp_class = n;
      end
    end
  endtask

  task automatic set_all(input int iv, input int wv, input int b0, input int b1, input int b2);
    for (int k = 0; k < IN; k++) in_mem[k] = DW'(iv);
    for (int k = 0; k < IN*OUT; k++) w_mem[k] = DW'(wv);
    b_mem[0] = DW'(b0);
    b_mem[1] = DW'(b1);
    b_mem[2] = DW'(b2);
  endtask

  task automatic check_idle(input string name);
    check({name, "_idle_en"}, {29'd0, in_en, w_en, b_en}, 0);
    check({name, "_idle_busy"}, busy, 0);
    check({name, "_idle_done"}, done, 0);
    check({name, "_idle_valid"}, out_valid, 0);
  endtask

  // One inference. restart_cyc/reset_cyc (0 = unused) inject a start or reset during that cycle.
  task automatic run(input string name, input int restart_cyc, input int reset_cyc, input bit addr_chk);
    int first_v;
    int done_c;
    bit aborted;
    exp_t e;
    first_v = -1;
    done_c = -1;
    aborted = 0;
    build_expect();
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (reset) begin
        check({name, "_rst_busy"}, busy, 0);
        check({name, "_rst_outs"}, {28'd0, out_valid, done, in_en, w_en}, 0);
        check({name, "_rst_class"}, class_idx, 0);
        reset = 1'b0;
        aborted = 1;
        break;
      end
      check({name, "_busy"}, busy, 1);
      if (out_valid) begin
        if (first_v < 0) first_v = cyc;
        if (sb.size() == 0) begin
          check({name, "_extra_valid"}, 1, 0);
        end else begin
          e = sb.pop_front();
          $display("%s cyc=%0d logit idx=%0d data=%0d", name, cyc, out_idx, $signed(out_data));
          check({name, "_idx"}, out_idx, e.idx);
          check({name, "_data"}, $signed(out_data), e.data);
        end
      end
      if (addr_chk && cyc == 15) begin
        check({name, "_b_en"}, b_en, 1);
        check({name, "_b_addr"}, b_addr, 2);
      end
      if (addr_chk && cyc == 19) begin
        check({name, "_mac_en"}, {30'd0, in_en, w_en}, 3);
        check({name, "_in_addr"}, in_addr, 3);
        check({name, "_w_addr"}, w_addr, 11);
      end
      if (done) begin
        done_c = cyc;
        check({name, "_class"}, class_idx, exp_class);
        break;
      end
      if (cyc == restart_cyc) start = 1'b1;
      if (cyc == reset_cyc) reset = 1'b1;
    end
    if (aborted) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        check_idle({name, "_post_abort"});
      end
      sb.delete();
    end else begin
      $display("%s done cyc=%0d first_valid=%0d class=%0d", name, done_c, first_v, class_idx);
      check({name, "_done_cycle"}, done_c, 22);
      check({name, "_first_valid"}, first_v, 7);
      check({name, "_sb_empty"}, sb.size(), 0);
      @(negedge clk);
      check_idle(name);
      check({name, "_class_held"}, class_idx, exp_class);
    end
  endtask

  initial begin
    set_all(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("reset_class", class_idx, 0);
    check("reset_data", {14'd0, out_idx, out_data}, 0);
    check_idle("reset");
    reset = 1'b0;
    @(negedge clk);
    check_idle("post_reset");

    set_all(128, 64, 0, 0, 0);
    run("t1_basic", 0, 0, 1);
    run("t5_restart", 4, 0, 0);
    run("t5_abort", 0, 10, 0);
    run("t5_rerun", 0, 0, 0);

    set_all(-1, 1, 0, 0, 0);
    run("t2_floor", 0, 0, 0);
    set_all(0, 0, -128, 128, 0);
    run("t2_bias", 0, 0, 0);

    set_all(32767, 32767, 0, 0, 0);
    for (int k = 0; k < IN; k++) begin
      w_mem[IN+k]   = -16'sd32768;
      w_mem[2*IN+k] = 16'sd0;
    end
    run("t3_sat", 0, 0, 0);

    set_all(0, 0, 5, 9, 9);
    run("t4_tie", 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
